// File: rtl/idct_pkg.sv
// idct_pkg: shared widths, state encoding and Q1.14 cosine ROM for the 8x8 IDCT
package idct_pkg;
   localparam int DW = 16;
   localparam int FB = 8;
   localparam int CB = 14;
   localparam int AW = 36;
   typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;
   function automatic logic signed [DW-1:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
      logic [4:0] p, f, g;
      logic neg;
      logic signed [DW-1:0] mag;
      p = {1'b0, n, 1'b1} * {2'b0, k};
      f = (p > 5'd16) ? 5'd0 - p : p;
      neg = f > 5'd8;
      g = neg ? 5'd16 - f : f;
      case (g)
         5'd0: mag = 16'sd8192;
         5'd1: mag = 16'sd8035;
         5'd2: mag = 16'sd7568;
         5'd3: mag = 16'sd6811;
         5'd4: mag = 16'sd5793;
         5'd5: mag = 16'sd4551;
         5'd6: mag = 16'sd3135;
         5'd7: mag = 16'sd1598;
         default: mag = 16'sd0;
      endcase
      return (k == 3'd0) ? 16'sd5793 : neg ? -mag : mag;
   endfunction
endpackage

// File: rtl/idct_mac.sv
// idct_mac: 8-term multiply-accumulate with half-up rounding to Q8.8; saturates when IDCT_SATURATE_EN is defined, else wraps
module idct_mac
   import idct_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic signed [DW-1:0] a_i,
   input  logic signed [DW-1:0] b_i,
   output logic signed [DW-1:0] res_o
);
   localparam logic signed [AW-1:0] HALF = {{(AW-CB){1'b0}}, 1'b1, {(CB-1){1'b0}}};
   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0] acc_q, acc_d;
   assign prod = a_i * b_i;
`ifdef IDCT_SATURATE_EN
   logic signed [AW-1:0] rnd;
   // accumulate, round half-up and clamp to the Q8.8 range
   always_comb begin
      acc_d = (clr_i ? '0 : acc_q) + AW'(prod);
      rnd = (acc_d + HALF) >>> CB;
      res_o = (rnd[AW-1:DW-1] != {(AW-DW+1){rnd[AW-1]}}) ?
              {rnd[AW-1], {(DW-1){~rnd[AW-1]}}} : rnd[DW-1:0];
   end
`else
   // accumulate, round half-up and keep the low 16 bits
   always_comb begin
      acc_d = (clr_i ? '0 : acc_q) + AW'(prod);
      res_o = DW'((acc_d + HALF) >>> CB);
   end
`endif
   // running sum, restarted on the first term of each entry
   always_ff @(posedge clk) begin
      if (!rst_n) acc_q <= '0;
      else if (en_i) acc_q <= acc_d;
   end
endmodule

// File: rtl/inverse_cosine_transform.sv
// inverse_cosine_transform: 8x8 IDCT, load 64 coefs, row pass, column pass, stream 64 samples; IDCT_SATURATE_EN selects saturation
module inverse_cosine_transform
   import idct_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] coef_in,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] pix_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);
   state_t state_q, state_d;
   logic [5:0] iidx_q, iidx_d;
   logic [8:0] cnt_q, cnt_d;
   logic [6:0] oidx_q, oidx_d;
   logic out_valid_q, out_valid_d;
   logic [DW-1:0] pix_q, pix_d;
   logic [DW-1:0] cmem [64];
   logic [DW-1:0] tmem [64];
   logic [2:0] r_e, c_e, t;
   logic in_hs, out_hs, last_term;
   logic [DW-1:0] mac_a, mac_b, mac_res;
   assign r_e = cnt_q[8:6];
   assign c_e = cnt_q[5:3];
   assign t = cnt_q[2:0];
   assign last_term = t == 3'd7;
   assign in_ready = state_q == LOAD;
   assign busy = state_q != LOAD;
   assign out_valid = out_valid_q;
   assign pix_out = pix_q;
   assign in_hs = in_valid && in_ready;
   assign out_hs = out_valid_q && out_ready;
   assign mac_a = (state_q == ROW) ? cmem[{r_e, t}] : cos_rom(t, r_e);
   assign mac_b = (state_q == ROW) ? cos_rom(t, c_e) : tmem[{t, c_e}];
   idct_mac u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (state_q == ROW || state_q == COL),
      .clr_i (t == 3'd0),
      .a_i   (mac_a),
      .b_i   (mac_b),
      .res_o (mac_res)
   );
   // sequencing: load, 512-cycle row pass, 512-cycle column pass, output stream
   always_comb begin
      state_d = state_q;
      iidx_d = iidx_q;
      cnt_d = cnt_q;
      oidx_d = oidx_q;
      out_valid_d = out_valid_q;
      pix_d = pix_q;
      case (state_q)
         LOAD: if (in_hs) begin
            iidx_d = iidx_q + 6'd1;
            if (iidx_q == 6'd63) begin
               state_d = ROW;
               cnt_d = '0;
            end
         end
         ROW: begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'd511) state_d = COL;
         end
         COL: begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'd511) begin
               state_d = OUT;
               oidx_d = '0;
            end
         end
         OUT: if (out_hs && oidx_q == 7'd64) begin
            state_d = LOAD;
            out_valid_d = 1'b0;
            oidx_d = '0;
         end else if ((!out_valid_q || out_hs) && oidx_q != 7'd64) begin
            pix_d = cmem[oidx_q[5:0]];
            out_valid_d = 1'b1;
            oidx_d = oidx_q + 7'd1;
         end
         default: state_d = LOAD;
      endcase
   end
   // control registers, all returned to idle by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LOAD;
         iidx_q <= '0;
         cnt_q <= '0;
         oidx_q <= '0;
         out_valid_q <= 1'b0;
         pix_q <= '0;
      end else begin
         state_q <= state_d;
         iidx_q <= iidx_d;
         cnt_q <= cnt_d;
         oidx_q <= oidx_d;
         out_valid_q <= out_valid_d;
         pix_q <= pix_d;
      end
   end
   // coefficient store doubles as the result store once the row pass has consumed X
   always_ff @(posedge clk) begin
      if (in_hs) cmem[iidx_q] <= coef_in;
      else if (state_q == COL && last_term) cmem[{r_e, c_e}] <= mac_res;
      if (state_q == ROW && last_term) tmem[{r_e, c_e}] <= mac_res;
   end
endmodule

// File: tb/tb_inverse_cosine_transform.sv
// tb_inverse_cosine_transform: randomized checks of the IDCT against a real-arithmetic matrix model
`timescale 1ns/1ps
module tb_inverse_cosine_transform;
   logic clk = 0;
   logic rst_n = 0;
   logic [15:0] coef_in = 0;
   logic in_valid = 0;
   logic in_ready;
   logic [15:0] pix_out;
   logic out_valid;
   logic out_ready = 0;
   logic busy;
   int checks = 0;
   int errors = 0;
   int a_tab [8][8];

   inverse_cosine_transform dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .coef_in   (coef_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pix_out   (pix_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int rnd_real(real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   function automatic logic [15:0] nar(longint r);
`ifdef IDCT_SATURATE_EN
      if (r > 32767) return 16'h7FFF;
      if (r < -32768) return 16'h8000;
`endif
      return r[15:0];
   endfunction

   task automatic model_idct(input logic [15:0] x[64], output logic [15:0] y[64]);
      logic [15:0] tm [64];
      longint s;
      for (int u = 0; u < 8; u++)
         for (int n = 0; n < 8; n++) begin
            s = 0;
            for (int v = 0; v < 8; v++) s += longint'($signed(x[u*8+v])) * a_tab[v][n];
            tm[u*8+n] = nar((s + 8192) >>> 14);
         end
      for (int m = 0; m < 8; m++)
         for (int n = 0; n < 8; n++) begin
            s = 0;
            for (int u = 0; u < 8; u++) s += longint'(a_tab[u][m]) * $signed(tm[u*8+n]);
            y[m*8+n] = nar((s + 8192) >>> 14);
         end
   endtask

   task automatic send_block(input logic [15:0] x[64], input bit gaps, input bit hold, input bit wait_out, output int lat);
      int i;
      bit hs;
      i = 0;
      lat = -1;
      out_ready = 0;
      for (int g = 0; g < 1000 && i < 64; g++) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 0;
            coef_in = 16'($urandom);
         end else begin
            in_valid = 1;
            coef_in = x[i];
         end
         hs = in_valid && in_ready;
         @(posedge clk);
         if (hs) i++;
      end
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (n == 0) begin
            in_valid = hold;
            coef_in = hold ? 16'h7FFF : 16'h0000;
         end
         if (!wait_out) break;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic collect(input bit rnd, output logic [15:0] got[64], output int n, output logic ir);
      n = 0;
      for (int c = 0; c < 4000 && n < 64; c++) begin
         @(negedge clk);
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (out_valid && out_ready) begin
            got[n] = pix_out;
            n++;
         end
      end
      @(negedge clk);
      ir = in_ready;
      in_valid = 0;
      out_ready = 0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      checks += 4;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      if (pix_out !== 16'h0000) begin errors++; $display("FAIL reset pix_out: got %h expected 0000", pix_out); end
      rst_n = 1;
   endtask

   task automatic test_dc_small;
      logic [15:0] x[64], y[64], got[64];
      int lat, n, bad;
      logic ir;
      foreach (x[k]) x[k] = 16'h0000;
      x[0] = 16'h0800;
      model_idct(x, y);
      send_block(x, 1, 0, 1, lat);
      collect(1, got, n, ir);
      bad = 0;
      checks += 2;
      if (n !== 64) begin errors++; $display("FAIL dc_small count: got %0d expected 64", n); end
      if (ir !== 1'b1) begin errors++; $display("FAIL dc_small in_ready after: got %b expected 1", ir); end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got[k] !== y[k]) begin errors++; $display("FAIL dc_small out[%0d]: got %h expected %h", k, got[k], y[k]); end
         if ($signed(got[k]) < 255 || $signed(got[k]) > 257) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL dc_small tolerance: %0d outputs outside 0x0100+-1, expected 0", bad); end
   endtask

   task automatic test_dc_latency;
      logic [15:0] x[64], got[64];
      int lat, n;
      logic ir;
      foreach (x[k]) x[k] = 16'h0000;
      x[0] = 16'h4000;
      send_block(x, 0, 0, 1, lat);
      checks++;
      if (lat !== 1025) begin errors++; $display("FAIL dc_latency cycles: got %0d expected 1025", lat); end
      collect(0, got, n, ir);
      checks += 2;
      if (n !== 64) begin errors++; $display("FAIL dc_latency count: got %0d expected 64", n); end
      if (ir !== 1'b1) begin errors++; $display("FAIL dc_latency in_ready after: got %b expected 1", ir); end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got[k] !== 16'h0800) begin errors++; $display("FAIL dc_latency out[%0d]: got %h expected 0800", k, got[k]); end
      end
   endtask

   task automatic test_saturation;
      logic [15:0] x[64], y[64], got[64];
      int lat, n;
      logic ir;
      foreach (x[k]) x[k] = 16'h7F00;
      model_idct(x, y);
      send_block(x, 0, 0, 1, lat);
      collect(1, got, n, ir);
      checks++;
`ifdef IDCT_SATURATE_EN
      if (got[0] !== 16'h7FFF) begin errors++; $display("FAIL saturation y00: got %h expected 7FFF", got[0]); end
`else
      if (got[0] === 16'h7FFF) begin errors++; $display("FAIL saturation y00: got %h expected wrapped value not 7FFF", got[0]); end
`endif
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got[k] !== y[k]) begin errors++; $display("FAIL saturation out[%0d]: got %h expected %h", k, got[k], y[k]); end
      end
   endtask

   task automatic test_random;
      logic [15:0] x[64], y[64], got[64];
      int lat, n;
      logic ir;
      for (int b = 0; b < 3; b++) begin
         foreach (x[k]) x[k] = (b == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 4096)) - 2048);
         model_idct(x, y);
         send_block(x, 1, 0, 1, lat);
         collect(1, got, n, ir);
         checks += 2;
         if (n !== 64) begin errors++; $display("FAIL random%0d count: got %0d expected 64", b, n); end
         if (ir !== 1'b1) begin errors++; $display("FAIL random%0d in_ready after: got %b expected 1", b, ir); end
         for (int k = 0; k < 64; k++) begin
            checks++;
            if (got[k] !== y[k]) begin errors++; $display("FAIL random%0d out[%0d]: got %h expected %h", b, k, got[k], y[k]); end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] x[64], y[64];
      int lat, n, stall;
      foreach (x[k]) x[k] = 16'($signed($urandom_range(0, 8192)) - 4096);
      model_idct(x, y);
      send_block(x, 0, 0, 1, lat);
      n = 0;
      stall = 0;
      for (int c = 0; c < 2000 && n < 64; c++) begin
         @(negedge clk);
         if (n == 5 && stall < 10) begin
            out_ready = 0;
            stall++;
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL backpressure hold valid: got %b expected 1", out_valid); end
            if (pix_out !== y[5]) begin errors++; $display("FAIL backpressure hold pix: got %h expected %h", pix_out, y[5]); end
         end else begin
            out_ready = 1;
            if (out_valid) begin
               checks++;
               if (pix_out !== y[n]) begin errors++; $display("FAIL backpressure out[%0d]: got %h expected %h", n, pix_out, y[n]); end
               n++;
            end
         end
      end
      @(negedge clk);
      out_ready = 0;
      checks += 2;
      if (n !== 64) begin errors++; $display("FAIL backpressure count: got %0d expected 64", n); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL backpressure in_ready after: got %b expected 1", in_ready); end
   endtask

   task automatic test_input_gating;
      logic [15:0] x[64], y[64], got[64];
      int lat, n;
      logic ir;
      foreach (x[k]) x[k] = 16'($urandom);
      model_idct(x, y);
      send_block(x, 0, 1, 1, lat);
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL gating in_ready busy: got %b expected 0", in_ready); end
      if (busy !== 1'b1) begin errors++; $display("FAIL gating busy: got %b expected 1", busy); end
      collect(1, got, n, ir);
      checks++;
      if (n !== 64) begin errors++; $display("FAIL gating count: got %0d expected 64", n); end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got[k] !== y[k]) begin errors++; $display("FAIL gating out[%0d]: got %h expected %h", k, got[k], y[k]); end
      end
   endtask

   task automatic test_mid_col_reset;
      logic [15:0] x[64], got[64];
      int lat, n;
      logic ir;
      foreach (x[k]) x[k] = 16'($urandom);
      send_block(x, 0, 0, 0, lat);
      repeat (700) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midcol busy before reset: got %b expected 1", busy); end
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      checks += 3;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midcol in_ready: got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midcol out_valid: got %b expected 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midcol busy: got %b expected 0", busy); end
      foreach (x[k]) x[k] = 16'h0000;
      x[0] = 16'h0800;
      send_block(x, 1, 0, 1, lat);
      collect(1, got, n, ir);
      checks++;
      if (n !== 64) begin errors++; $display("FAIL midcol count: got %0d expected 64", n); end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got[k] !== 16'h0100) begin errors++; $display("FAIL midcol out[%0d]: got %h expected 0100", k, got[k]); end
      end
   endtask

   initial begin
      for (int k = 0; k < 8; k++)
         for (int n = 0; n < 8; n++)
            a_tab[k][n] = (k == 0) ? rnd_real(16384.0 * $sqrt(0.125))
                                   : rnd_real(8192.0 * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0));
      test_reset();
      test_dc_small();
      test_dc_latency();
      test_saturation();
      test_random();
      test_backpressure();
      test_input_gating();
      test_mid_col_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
